// File: rtl/sha256_padder.sv
// sha256_padder: SHA-256 padding and 512-bit block framing; defining SHA256_PADDER_ERR_EN adds a sticky err_o
module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    input  logic         in_last_i,
    input  logic [2:0]   in_nbytes_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic [511:0] blk_o,
    output logic         blk_first_o,
    output logic         blk_last_o
`ifdef SHA256_PADDER_ERR_EN
    ,
    output logic         err_o
`endif
);
    typedef enum logic [2:0] {IDLE, FILL, FULL, PAD, XBLK, LASTBLK} state_t;
    state_t state, state_nx;
    logic [31:0] words [16];
    logic [3:0]  widx;
    logic [60:0] bcnt;
    logic [6:0]  ppos;
    logic [2:0]  nb;
    logic [63:0] len;
    logic        sent, accept, blk_hs;
    // ppos is the byte offset of the 0x80 marker within the block; 64 means it spills into a new block
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [4:0] i, input logic [6:0] p);
        logic [31:0] mask, mark;
        mask = ~(32'hffffffff >> {p[1:0], 3'b000});
        mark = 32'h80000000 >> {p[1:0], 3'b000};
        return i < p[6:2] ? w : i == p[6:2] ? (w & mask) | mark : 32'h0;
    endfunction
    assign nb     = !in_last_i || in_nbytes_i > 3'd4 ? 3'd4 : in_nbytes_i;
    assign len    = {bcnt, 3'b000};
    assign accept = in_valid_i && in_ready_o;
    assign blk_hs = blk_valid_o && blk_ready_i;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FILL: if (accept) state_nx = in_last_i ? PAD : widx == 4'd15 ? FULL : FILL;
            FULL:       if (blk_hs) state_nx = FILL;
            PAD:        state_nx = ppos < 7'd56 ? LASTBLK : XBLK;
            XBLK:       if (blk_hs) state_nx = LASTBLK;
            LASTBLK:    if (blk_hs) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready_o  = !rst && (state == IDLE || state == FILL);
        blk_valid_o = !rst && (state == FULL || state == XBLK || state == LASTBLK);
        blk_first_o = blk_valid_o && !sent;
        blk_last_o  = blk_valid_o && state == LASTBLK;
        for (int i = 0; i < 16; i++) blk_o[511 - 32*i -: 32] = words[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            widx <= '0;
            bcnt <= '0;
            ppos <= '0;
            sent <= 1'b0;
        end else begin
            if (accept) begin
                words[widx] <= in_data_i;
                widx        <= widx + 4'd1;
                bcnt        <= bcnt + 61'(nb);
                ppos        <= {1'b0, widx, 2'b00} + 7'(nb);
            end
            if (state == PAD) begin
                for (int i = 0; i < 16; i++) words[i] <= pad_word(words[i], 5'(i), ppos);
                if (ppos < 7'd56) begin
                    words[14] <= len[63:32];
                    words[15] <= len[31:0];
                end
            end
            if (blk_hs) sent <= state != LASTBLK;
            if (blk_hs && state == XBLK) begin
                for (int i = 0; i < 16; i++) words[i] <= '0;
                words[0]  <= ppos[6] ? 32'h80000000 : 32'h0;
                words[14] <= len[63:32];
                words[15] <= len[31:0];
            end
            if (blk_hs && state == LASTBLK) begin
                widx <= '0;
                bcnt <= '0;
            end
        end
    end
`ifdef SHA256_PADDER_ERR_EN
    logic wrap;
    assign wrap = bcnt > ({61{1'b1}} - 61'(nb));
    always_ff @(posedge clk) err_o <= rst ? 1'b0 : err_o | (accept && ((in_last_i && in_nbytes_i > 3'd4) || wrap));
`endif
endmodule
